// File: rtl/pp_pkg.sv
// Shared definitions for the post-process frame monitor: FSM state encoding
// and default sample/counter widths.
package pp_pkg;

  localparam int PP_DATA_W = 16;
  localparam int PP_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } pp_state_t;

endpackage

// File: rtl/pp_peak_track.sv
// One channel of peak tracking: running signed maximum and its sample index,
// plus a result register loaded when the frame completes.
module pp_peak_track #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_acc,
  input  logic              i_commit,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [CNT_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_peak_val,
  output logic [CNT_W-1:0]  o_peak_idx
);

  logic [DATA_W-1:0] r_max;
  logic [CNT_W-1:0]  r_max_idx;
  logic [DATA_W-1:0] r_peak_val;
  logic [CNT_W-1:0]  r_peak_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max      <= '0;
      r_max_idx  <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else begin
      // Strictly-greater update keeps the earliest index on ties
      if (i_init) begin
        r_max     <= i_sample;
        r_max_idx <= '0;
      end else if (i_acc && ($signed(i_sample) > $signed(r_max))) begin
        r_max     <= i_sample;
        r_max_idx <= i_idx;
      end
      if (i_commit) begin
        r_peak_val <= r_max;
        r_peak_idx <= r_max_idx;
      end
    end
  end

  assign o_peak_val = r_peak_val;
  assign o_peak_idx = r_peak_idx;

endmodule

// File: rtl/pp_frame_monitor.sv
// Frame monitor: counts samples, above-threshold cycles and per-channel peaks
// for each valid-qualified frame. Define PP_LEN_CHECK_EN to enable len_err.
module pp_frame_monitor
  import pp_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = PP_DATA_W,
  parameter int CNT_W  = PP_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pp_enable,
  input  logic                     data_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0]        thresh,
  input  logic [CNT_W-1:0]         expected_len,
  output logic                     pp_working,
  output logic                     pp_done,
  output logic                     pp_abort,
  output logic [CNT_W-1:0]         frame_len,
  output logic [CNT_W-1:0]         over_cnt,
  output logic [NUM_CH*DATA_W-1:0] peak_val,
  output logic [NUM_CH*CNT_W-1:0]  peak_idx,
  output logic                     len_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pp_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_over;
  logic [DATA_W-1:0] r_thresh;
  logic              r_working;
  logic              r_done;
  logic              r_abort;
  logic [CNT_W-1:0]  r_frame_len;
  logic [CNT_W-1:0]  r_over_cnt;

  logic              w_start;
  logic              w_acc;
  logic              w_end;
  logic [DATA_W-1:0] w_thr;
  logic [NUM_CH-1:0] w_over_vec;
  logic              w_any_over;

  assign w_start = (r_state == S_IDLE) && pp_enable && data_valid_in;
  assign w_acc   = (r_state == S_RUN)  && pp_enable && data_valid_in;
  assign w_end   = (r_state == S_RUN)  && pp_enable && !data_valid_in;

  // The first sample is compared against the live threshold; later ones use the latched copy
  assign w_thr = (r_state == S_IDLE) ? thresh : r_thresh;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_over_vec[gi] =
        $signed(data_in[gi*DATA_W +: DATA_W]) > $signed(w_thr);

      pp_peak_track #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_start),
        .i_acc      (w_acc),
        .i_commit   (w_end),
        .i_sample   (data_in[gi*DATA_W +: DATA_W]),
        .i_idx      (r_cnt),
        .o_peak_val (peak_val[gi*DATA_W +: DATA_W]),
        .o_peak_idx (peak_idx[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign w_any_over = |w_over_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_over      <= '0;
      r_thresh    <= '0;
      r_working   <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_frame_len <= '0;
      r_over_cnt  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_working <= 1'b1;
            r_cnt     <= CNT_ONE;
            r_over    <= w_any_over ? CNT_ONE : '0;
            r_thresh  <= thresh;
          end
        end
        S_RUN: begin
          if (!pp_enable) begin
            r_state   <= S_IDLE;
            r_working <= 1'b0;
            r_abort   <= 1'b1;
          end else if (data_valid_in) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
            if (w_any_over && (r_over != CNT_MAX)) r_over <= r_over + CNT_ONE;
          end else begin
            r_state     <= S_DONE;
            r_working   <= 1'b0;
            r_done      <= 1'b1;
            r_frame_len <= r_cnt;
            r_over_cnt  <= r_over;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_working <= 1'b0;
        end
      endcase
    end
  end

`ifdef PP_LEN_CHECK_EN
  logic [CNT_W-1:0] r_exp_len;
  logic             r_len_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_len <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_start) r_exp_len <= expected_len;
      if (w_end)   r_len_err <= (r_cnt != r_exp_len);
    end
  end

  assign len_err = r_len_err;
`else
  logic w_unused_exp_len;
  assign w_unused_exp_len = ^expected_len;
  assign len_err          = 1'b0;
`endif

  assign pp_working = r_working;
  assign pp_done    = r_done;
  assign pp_abort   = r_abort;
  assign frame_len  = r_frame_len;
  assign over_cnt   = r_over_cnt;

endmodule

// File: doc/pp_frame_monitor.md
PP_FRAME_MONITOR -- requirements
Module: pp_frame_monitor

Interface
REQ-001 Parameter NUM_CH, default 2, number of ADC channels monitored (1..4).
REQ-002 Parameter DATA_W, default 16, signed sample width per channel.
REQ-003 Parameter CNT_W, default 16, width of all sample/event counters.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pp_enable  in  1  post-process enable; low forces IDLE.
REQ-007 data_valid_in  in  1  frame-active qualifier; one sample per channel per high cycle.
REQ-008 data_in  in  NUM_CH*DATA_W  packed signed samples, ch0 in LSBs.
REQ-009 thresh  in  DATA_W  signed threshold, sampled at frame start.
REQ-010 expected_len  in  CNT_W  expected samples per frame, sampled at frame start.
REQ-011 pp_working  out  1  high while state is RUN.
REQ-012 pp_done  out  1  one-cycle pulse at normal frame end.
REQ-013 pp_abort  out  1  one-cycle pulse when a frame is cut by pp_enable low.
REQ-014 frame_len  out  CNT_W  samples in last completed frame.
REQ-015 over_cnt  out  CNT_W  cycles in last frame where any channel sample > thresh.
REQ-016 peak_val  out  NUM_CH*DATA_W  per-channel signed maximum of last frame.
REQ-017 peak_idx  out  NUM_CH*CNT_W  per-channel sample index (0-based) of that maximum.
REQ-018 len_err  out  1  last frame_len != expected_len (PP_LEN_CHECK_EN only).

Function
REQ-019 FSM states IDLE, RUN, DONE; state encoding in package.
REQ-020 IDLE->RUN when pp_enable=1 and data_valid_in=1; that cycle's sample is index 0 and is accumulated.
REQ-021 RUN stays while data_valid_in=1, accumulating each cycle.
REQ-022 RUN->DONE on first cycle with data_valid_in=0 and pp_enable=1; pp_done asserted in that DONE cycle (1-cycle latency after valid falls).
REQ-023 DONE->IDLE unconditionally next cycle; valid high during DONE is ignored (not counted, no new frame until IDLE).
REQ-024 pp_enable=0 in RUN -> IDLE next cycle, pp_abort pulses, result outputs unchanged.
REQ-025 Result outputs (frame_len, over_cnt, peak_*, len_err) update only on entry to DONE and hold until next DONE.
REQ-026 Sample and over counters saturate at 2^CNT_W-1; no wrap.
REQ-027 Peak update only on strictly greater signed value; ties keep earliest index; index 0 sample initialises peak.
REQ-028 Threshold compare signed, strict >; thresh/expected_len changes during RUN have no effect.
REQ-029 pp_working registered: high in every RUN cycle, low in IDLE/DONE.

Reset
REQ-030 rst high: state IDLE, all outputs and internal accumulators 0, asynchronously.
REQ-031 rst mid-frame discards the frame; no pp_done or pp_abort pulse.

Configuration
REQ-032 Macro PP_LEN_CHECK_EN defined: len_err = (frame_len != expected_len latched), updated per REQ-025.
REQ-033 Macro undefined: len_err tied 0, expected_len unused, no latch register.

Structure
REQ-034 Package pp_pkg holds FSM state typedef, default DATA_W/CNT_W constants.
REQ-035 Sub-module pp_peak_track (one channel: running max, index, init, result register) instantiated NUM_CH times via generate.

Verification
REQ-036 NUM_CH=2, valid high 8 cycles, ch0 samples 1..8, ch1 all -5, thresh=4 -> pp_done one cycle after valid falls, frame_len=8, over_cnt=4, peak ch0=8 idx 7, ch1=-5 idx 0.
REQ-037 Ch0 samples 3,9,9,2 -> peak_val=9, peak_idx=1 (tie keeps first).
REQ-038 pp_enable dropped at 3rd sample of frame -> pp_abort pulse, no pp_done, previous results held.
REQ-039 CNT_W=4, 20-cycle frame -> frame_len=15, over_cnt saturates at 15.
REQ-040 PP_LEN_CHECK_EN, expected_len=10, frames of 10 and 9 -> len_err 0 then 1; rst asserted mid-frame -> all outputs 0, no pulse.
